hms_clock_gen2: RTL and testbench
=================================

Name: hms_clock_gen2

Overview:
Second-generation hour/minute/second timekeeping core with the following capabilities:
- A parametrised clock prescaler.
- Run-time 12h/24h display mode.
- Optional packed-BCD outputs.
- Validated synchronous time load.
- Minute-resolution alarm.

Time is kept internally as a 24h binary count. Display outputs are derived from that count. The block sits between the system clock domain and the display/seven-segment drivers.

Parameters:
- CLK_DIV, default 1: clk cycles per one-second tick while enabled (≥1). A value of 1 means every enabled clk edge is a second.
- OUT_BCD, default 0: 0 = hour/min/sec and load_* are binary; 1 = they are packed BCD ({tens, ones} nibbles).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- ena  input  1  count enable; prescaler and time hold when low
- mode24  input  1  0 = 12h display, 1 = 24h display; display only, never affects the count
- load  input  1  synchronous time load strobe
- load_hour  input  8  hour to load (format per mode24/OUT_BCD)
- load_min  input  8  minute to load
- load_sec  input  8  second to load
- load_pm  input  1  PM flag for load in 12h mode; ignored in 24h mode
- alarm_on  input  1  alarm enable
- alarm_h24  input  5  alarm hour, binary 0..23
- alarm_min  input  6  alarm minute, binary 0..59
- hour  output  8  displayed hour
- min  output  8  displayed minute
- sec  output  8  displayed second
- pm  output  1  PM indicator (12h mode only; 0 in 24h)
- tick  output  1  one-cycle pulse on each second advance
- day_wrap  output  1  one-cycle pulse when time wraps 23:59:59 → 00:00:00
- alarm  output  1  one-cycle alarm pulse
- load_err  output  1  one-cycle pulse when a load is rejected

Behaviour:
- Internal state:
  - h24 (0..23), m (0..59), s (0..59).
  - Prescaler div (0..CLK_DIV-1).
  - Registered pulse flags: tick, day_wrap, alarm, load_err.
- Reset (async, immediate):
  - h24 = m = s = 0; div = 0.
  - tick = day_wrap = alarm = load_err = 0.
  - Outputs: hour = 12 (12h mode) or 0 (24h mode); min = sec = 0; pm = 0.
  - On release, counting resumes on the first rising clk edge with ena = 1.
- Prescaler:
  - When ena = 1: div increments each edge. At div == CLK_DIV-1 a second advance occurs and div returns to 0.
  - When ena = 0: div, h24, m and s hold.
  - Second advance rules:
    - s increments.
    - At s = 59: s → 0 and m increments.
    - At m = 59: m → 0 and h24 increments.
    - At h24 = 23: h24 → 0.
- Pulses:
  - All pulses are registered and asserted during the cycle after the edge that caused them. This is the same cycle in which the outputs show the new time.
  - Each pulse deasserts the following cycle unless the event repeats.
  - day_wrap accompanies the advance into 00:00:00.
- Alarm:
  - Fires on a second advance whose new time equals alarm_h24:alarm_min:00, provided alarm_on = 1.
  - Loads never trigger the alarm.
- Load:
  - Sampled on a clk edge with load = 1. Load has priority over a simultaneous second advance; that advance is dropped.
  - Load is honoured regardless of ena.
  - A valid load sets h24/m/s, clears div, and produces no tick.
- Load validation:
  - min and sec must be 0..59.
  - hour must be 1..12 in 12h mode, 0..23 in 24h mode.
  - With OUT_BCD = 1, any nibble > 9 is invalid.
  - Invalid loads leave all state unchanged and pulse load_err.
- 12h load conversion:
  - 12 AM → h24 = 0; 12 PM → h24 = 12.
  - Otherwise h24 = hour + 12·load_pm.
- Display (combinational from h24/m/s and mode24, zero latency):
  - 12h mode: hour = (h24 mod 12 == 0) ? 12 : h24 mod 12; pm = (h24 ≥ 12).
  - 24h mode: hour = h24; pm = 0.
  - With OUT_BCD = 1, all three fields are converted to packed BCD.
- mode24 may change in any cycle. The display follows immediately; the count is unaffected.

Test Plan:
1. Reset asserted mid-count (time 03:15:42), asynchronously, no clk edge → hour = 12, min = 0, sec = 0, pm = 0, all pulses 0 immediately.
2. CLK_DIV = 4, ena = 1 for 8 edges then 0 for 5 edges → exactly 2 tick pulses, each 4 cycles apart; sec = 2 and holds while ena = 0.
3. Load 11:59:59 with load_pm = 1 in 12h mode, then one advance → hour = 12, pm = 0, min = 0, sec = 0 displayed as 12 AM; day_wrap pulses one cycle. Switching mode24 = 1 shows hour = 0.
4. Load with min = 60, and separately load hour = 0 in 12h mode → load_err pulses, time unchanged. Load coincident with a tick → loaded value wins, no tick pulse.
5. alarm_on = 1, alarm 07:30, load 07:29:59 and advance → alarm pulses for one cycle with outputs 07:30:00. Loading 07:30:00 directly → no alarm.
6. OUT_BCD = 1, 24h mode, load 8'h23/8'h59/8'h58, two advances → outputs 8'h00/8'h00/8'h00 and day_wrap pulses. Load min = 8'h5A → load_err.

Source files
------------

// File: rtl/hms_clock_gen2.sv
// hms_clock_gen2: hour/minute/second timekeeper with a prescaler, 12h/24h display,
// optional packed-BCD I/O, validated synchronous load and a minute-resolution alarm.
module hms_clock_gen2 #(
  parameter int CLK_DIV = 1,
  parameter bit OUT_BCD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic       mode24,
  input  logic       load,
  input  logic [7:0] load_hour,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  input  logic       load_pm,
  input  logic       alarm_on,
  input  logic [4:0] alarm_h24,
  input  logic [5:0] alarm_min,
  output logic [7:0] hour,
  output logic [7:0] min,
  output logic [7:0] sec,
  output logic       pm,
  output logic       tick,
  output logic       day_wrap,
  output logic       alarm,
  output logic       load_err
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  function automatic logic [7:0] bcd_to_bin(input logic [7:0] v);
    return ({4'd0, v[7:4]} * 8'd10) + {4'd0, v[3:0]};
  endfunction

  function automatic logic [7:0] bin_to_bcd(input logic [7:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 8'd10);
    ones = 4'(v % 8'd10);
    return {tens, ones};
  endfunction

  function automatic logic nibbles_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  logic [DIV_W-1:0] r_div;
  logic [4:0]       r_h24;
  logic [5:0]       r_m;
  logic [5:0]       r_s;
  logic             r_tick;
  logic             r_day_wrap;
  logic             r_alarm;
  logic             r_load_err;

  // Load decode: everything is validated in binary after optional BCD conversion.
  logic [7:0] w_ld_h;
  logic [7:0] w_ld_m;
  logic [7:0] w_ld_s;
  logic       w_bcd_ok;
  logic       w_h_ok;
  logic       w_ld_ok;
  logic [4:0] w_ld_h24;

  assign w_ld_h   = OUT_BCD ? bcd_to_bin(load_hour) : load_hour;
  assign w_ld_m   = OUT_BCD ? bcd_to_bin(load_min)  : load_min;
  assign w_ld_s   = OUT_BCD ? bcd_to_bin(load_sec)  : load_sec;
  assign w_bcd_ok = !OUT_BCD ||
                    (nibbles_ok(load_hour) && nibbles_ok(load_min) && nibbles_ok(load_sec));
  assign w_h_ok   = mode24 ? (w_ld_h <= 8'd23) : ((w_ld_h >= 8'd1) && (w_ld_h <= 8'd12));
  assign w_ld_ok  = w_bcd_ok && w_h_ok && (w_ld_m <= 8'd59) && (w_ld_s <= 8'd59);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_ld_h24 = w_ld_h[4:0];
    if (!mode24) begin
      if (w_ld_h == 8'd12) w_ld_h24 = load_pm ? 5'd12 : 5'd0;
      else                 w_ld_h24 = w_ld_h[4:0] + (load_pm ? 5'd12 : 5'd0);
    end
  end

  logic       w_div_last;
  logic       w_s_wrap;
  logic       w_m_wrap;
  logic       w_h_wrap;
  logic       w_day_wrap;
  logic       w_alarm_hit;
  logic [4:0] w_h_nxt;
  logic [5:0] w_m_nxt;
  logic [5:0] w_s_nxt;

  assign w_div_last = (r_div == DIV_LAST);
  assign w_s_wrap   = (r_s == 6'd59);
  assign w_m_wrap   = (r_m == 6'd59);
  assign w_h_wrap   = (r_h24 == 5'd23);
  assign w_day_wrap = w_s_wrap && w_m_wrap && w_h_wrap;

  always_comb begin
    w_s_nxt = r_s + 6'd1;
    w_m_nxt = r_m;
    w_h_nxt = r_h24;
    if (w_s_wrap) begin
      w_s_nxt = 6'd0;
      w_m_nxt = r_m + 6'd1;
      if (w_m_wrap) begin
        w_m_nxt = 6'd0;
        w_h_nxt = w_h_wrap ? 5'd0 : r_h24 + 5'd1;
      end
    end
  end

  assign w_alarm_hit = alarm_on && (w_s_nxt == 6'd0) &&
                       (w_m_nxt == alarm_min) && (w_h_nxt == alarm_h24);

  // A load, valid or not, preempts any second advance on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div      <= '0;
      r_h24      <= 5'd0;
      r_m        <= 6'd0;
      r_s        <= 6'd0;
      r_tick     <= 1'b0;
      r_day_wrap <= 1'b0;
      r_alarm    <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_tick     <= 1'b0;
      r_day_wrap <= 1'b0;
      r_alarm    <= 1'b0;
      r_load_err <= 1'b0;
      if (load) begin
        if (w_ld_ok) begin
          r_h24 <= w_ld_h24;
          r_m   <= w_ld_m[5:0];
          r_s   <= w_ld_s[5:0];
          r_div <= '0;
        end else begin
          r_load_err <= 1'b1;
        end
      end else if (ena) begin
        if (w_div_last) begin
          r_div      <= '0;
          r_h24      <= w_h_nxt;
          r_m        <= w_m_nxt;
          r_s        <= w_s_nxt;
          r_tick     <= 1'b1;
          r_day_wrap <= w_day_wrap;
          r_alarm    <= w_alarm_hit;
        end else begin
          r_div <= r_div + 1'b1;
        end
      end
    end
  end

  logic [4:0] w_h_mod;
  logic [4:0] w_h12;
  logic [7:0] w_hour_bin;
  logic [7:0] w_min_bin;
  logic [7:0] w_sec_bin;

  assign w_h_mod    = (r_h24 >= 5'd12) ? (r_h24 - 5'd12) : r_h24;
  assign w_h12      = (w_h_mod == 5'd0) ? 5'd12 : w_h_mod;
  assign w_hour_bin = mode24 ? {3'd0, r_h24} : {3'd0, w_h12};
  assign w_min_bin  = {2'd0, r_m};
  assign w_sec_bin  = {2'd0, r_s};

  assign hour     = OUT_BCD ? bin_to_bcd(w_hour_bin) : w_hour_bin;
  assign min      = OUT_BCD ? bin_to_bcd(w_min_bin)  : w_min_bin;
  assign sec      = OUT_BCD ? bin_to_bcd(w_sec_bin)  : w_sec_bin;
  assign pm       = !mode24 && (r_h24 >= 5'd12);
  assign tick     = r_tick;
  assign day_wrap = r_day_wrap;
  assign alarm    = r_alarm;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_hms_clock_gen2.sv
// Directed bench for hms_clock_gen2: binary CLK_DIV=1, binary CLK_DIV=4 and BCD instances.
module tb_hms_clock_gen2;

  logic       clk = 1'b0;
  logic       reset, ena, mode24, load_pm, alarm_on;
  logic       load_b, load_c;
  logic [7:0] lh_b, lm_b, ls_b, lh_c, lm_c, ls_c;
  logic [4:0] alarm_h24;
  logic [5:0] alarm_min;

  logic [7:0] b_hour, b_min, b_sec, d_hour, d_min, d_sec, c_hour, c_min, c_sec;
  logic       b_pm, b_tick, b_wrap, b_alarm, b_err;
  logic       d_pm, d_tick, d_wrap, d_alarm, d_err;
  logic       c_pm, c_tick, c_wrap, c_alarm, c_err;

  int total = 0;
  int bad   = 0;
  int n_ticks;

  always #5 clk = ~clk;

  hms_clock_gen2 #(.CLK_DIV(1), .OUT_BCD(1'b0)) dut_b (
    .clk(clk), .reset(reset), .ena(ena), .mode24(mode24), .load(load_b),
    .load_hour(lh_b), .load_min(lm_b), .load_sec(ls_b), .load_pm(load_pm),
    .alarm_on(alarm_on), .alarm_h24(alarm_h24), .alarm_min(alarm_min),
    .hour(b_hour), .min(b_min), .sec(b_sec), .pm(b_pm), .tick(b_tick),
    .day_wrap(b_wrap), .alarm(b_alarm), .load_err(b_err));

  hms_clock_gen2 #(.CLK_DIV(4), .OUT_BCD(1'b0)) dut_d (
    .clk(clk), .reset(reset), .ena(ena), .mode24(mode24), .load(load_b),
    .load_hour(lh_b), .load_min(lm_b), .load_sec(ls_b), .load_pm(load_pm),
    .alarm_on(alarm_on), .alarm_h24(alarm_h24), .alarm_min(alarm_min),
    .hour(d_hour), .min(d_min), .sec(d_sec), .pm(d_pm), .tick(d_tick),
    .day_wrap(d_wrap), .alarm(d_alarm), .load_err(d_err));

  hms_clock_gen2 #(.CLK_DIV(1), .OUT_BCD(1'b1)) dut_c (
    .clk(clk), .reset(reset), .ena(ena), .mode24(mode24), .load(load_c),
    .load_hour(lh_c), .load_min(lm_c), .load_sec(ls_c), .load_pm(load_pm),
    .alarm_on(alarm_on), .alarm_h24(alarm_h24), .alarm_min(alarm_min),
    .hour(c_hour), .min(c_min), .sec(c_sec), .pm(c_pm), .tick(c_tick),
    .day_wrap(c_wrap), .alarm(c_alarm), .load_err(c_err));

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; ena = 1'b0; mode24 = 1'b0; load_pm = 1'b0; alarm_on = 1'b0;
    load_b = 1'b0; load_c = 1'b0;
    lh_b = 8'd0; lm_b = 8'd0; ls_b = 8'd0; lh_c = 8'd0; lm_c = 8'd0; ls_c = 8'd0;
    alarm_h24 = 5'd0; alarm_min = 6'd0;
    #12 reset = 1'b0;
    check("rst_hour12", b_hour, 8'd12);
    check("rst_bcd_hour", c_hour, 8'h12);
    check("rst_sec", b_sec, 8'd0);

    // 1: async reset mid-count from 03:15:42
    mode24 = 1'b1; load_b = 1'b1; lh_b = 8'd3; lm_b = 8'd15; ls_b = 8'd42;
    step();
    load_b = 1'b0;
    check("t1_ld_hour", b_hour, 8'd3);
    check("t1_ld_min", b_min, 8'd15);
    check("t1_ld_sec", b_sec, 8'd42);
    ena = 1'b1;
    step(); step(); step();
    check("t1_cnt_sec", b_sec, 8'd45);
    check("t1_cnt_tick", {7'd0, b_tick}, 8'd1);
    #3 reset = 1'b1; mode24 = 1'b0;
    #1;
    check("t1_rst_hour", b_hour, 8'd12);
    check("t1_rst_min", b_min, 8'd0);
    check("t1_rst_sec", b_sec, 8'd0);
    check("t1_rst_pm", {7'd0, b_pm}, 8'd0);
    check("t1_rst_pulses", {4'd0, b_tick, b_wrap, b_alarm, b_err}, 8'd0);

    // 2: CLK_DIV=4, 8 enabled edges then 5 held edges
    #2 reset = 1'b0;
    n_ticks = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      check("t2_tick", {7'd0, d_tick}, 8'((i % 4) == 0));
      if (d_tick) n_ticks++;
    end
    ena = 1'b0;
    check("t2_sec", d_sec, 8'd2);
    for (int i = 0; i < 5; i++) begin
      step();
      if (d_tick) n_ticks++;
      check("t2_hold_sec", d_sec, 8'd2);
    end
    check("t2_tick_count", 8'(n_ticks), 8'd2);

    // 3: 11:59:59 PM in 12h mode wraps to 12 AM
    mode24 = 1'b0; load_pm = 1'b1; load_b = 1'b1;
    lh_b = 8'd11; lm_b = 8'd59; ls_b = 8'd59;
    step();
    load_b = 1'b0;
    check("t3_ld_hour", b_hour, 8'd11);
    check("t3_ld_pm", {7'd0, b_pm}, 8'd1);
    ena = 1'b1;
    step();
    ena = 1'b0;
    check("t3_wrap_hour", b_hour, 8'd12);
    check("t3_wrap_pm", {7'd0, b_pm}, 8'd0);
    check("t3_wrap_min", b_min, 8'd0);
    check("t3_wrap_sec", b_sec, 8'd0);
    check("t3_day_wrap", {7'd0, b_wrap}, 8'd1);
    step();
    check("t3_day_wrap_off", {7'd0, b_wrap}, 8'd0);
    mode24 = 1'b1;
    #1;
    check("t3_mode24_hour", b_hour, 8'd0);

    // 4: rejected loads, then load colliding with an advance
    mode24 = 1'b0; load_pm = 1'b0; load_b = 1'b1;
    lh_b = 8'd5; lm_b = 8'd60; ls_b = 8'd0;
    step();
    check("t4_err_min60", {7'd0, b_err}, 8'd1);
    check("t4_min60_hold", b_hour, 8'd12);
    lh_b = 8'd0; lm_b = 8'd10;
    step();
    check("t4_err_hour0", {7'd0, b_err}, 8'd1);
    check("t4_hour0_hold_min", b_min, 8'd0);
    load_b = 1'b0;
    step();
    check("t4_err_off", {7'd0, b_err}, 8'd0);
    ena = 1'b1; load_b = 1'b1; lh_b = 8'd10; lm_b = 8'd20; ls_b = 8'd30;
    step();
    load_b = 1'b0;
    check("t4_coll_hour", b_hour, 8'd10);
    check("t4_coll_sec", b_sec, 8'd30);
    check("t4_coll_tick", {7'd0, b_tick}, 8'd0);
    step();
    ena = 1'b0;
    check("t4_next_sec", b_sec, 8'd31);
    check("t4_next_tick", {7'd0, b_tick}, 8'd1);
    load_b = 1'b1; lh_b = 8'd12; lm_b = 8'd0; ls_b = 8'd0;
    step();
    load_b = 1'b0; mode24 = 1'b1;
    #1;
    check("t4_12am_h24", b_hour, 8'd0);

    // 5: alarm on advance, not on load
    alarm_on = 1'b1; alarm_h24 = 5'd7; alarm_min = 6'd30;
    load_b = 1'b1; lh_b = 8'd7; lm_b = 8'd29; ls_b = 8'd59;
    step();
    load_b = 1'b0;
    check("t5_ld_alarm", {7'd0, b_alarm}, 8'd0);
    ena = 1'b1;
    step();
    check("t5_alarm", {7'd0, b_alarm}, 8'd1);
    check("t5_alarm_hour", b_hour, 8'd7);
    check("t5_alarm_min", b_min, 8'd30);
    check("t5_alarm_sec", b_sec, 8'd0);
    step();
    ena = 1'b0;
    check("t5_alarm_off", {7'd0, b_alarm}, 8'd0);
    load_b = 1'b1; ls_b = 8'd0; lm_b = 8'd30;
    step();
    load_b = 1'b0;
    check("t5_load_no_alarm", {7'd0, b_alarm}, 8'd0);
    check("t5_load_min", b_min, 8'd30);
    alarm_on = 1'b0;

    // 6: packed-BCD instance
    load_c = 1'b1; lh_c = 8'h23; lm_c = 8'h59; ls_c = 8'h58;
    step();
    load_c = 1'b0;
    check("t6_ld_hour", c_hour, 8'h23);
    check("t6_ld_sec", c_sec, 8'h58);
    ena = 1'b1;
    step();
    check("t6_sec59", c_sec, 8'h59);
    step();
    ena = 1'b0;
    check("t6_wrap_hour", c_hour, 8'h00);
    check("t6_wrap_min", c_min, 8'h00);
    check("t6_wrap_sec", c_sec, 8'h00);
    check("t6_day_wrap", {7'd0, c_wrap}, 8'd1);
    load_c = 1'b1; lh_c = 8'h10; lm_c = 8'h5A; ls_c = 8'h00;
    step();
    check("t6_err_nibble", {7'd0, c_err}, 8'd1);
    check("t6_err_hold_hour", c_hour, 8'h00);
    mode24 = 1'b0; load_pm = 1'b1; lh_c = 8'h12; lm_c = 8'h05; ls_c = 8'h00;
    step();
    load_c = 1'b0;
    check("t6_12pm_hour", c_hour, 8'h12);
    check("t6_12pm_pm", {7'd0, c_pm}, 8'd1);
    check("t6_12pm_min", c_min, 8'h05);
    mode24 = 1'b1;
    #1;
    check("t6_24h_hour", c_hour, 8'h12);
    check("t6_24h_pm", {7'd0, c_pm}, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
